// File: rtl/gen_gpo_ctrl_regs.sv
// Parametrised GPO control registers on AVMM: VALUE/SET/CLEAR/LOCK
// per 32-bit bank, optional self-clearing pulse bits, change strobe.
module gen_gpo_ctrl_regs #(
  parameter int          GPO_WIDTH    = 30,
  parameter logic [63:0] RESET_VALUE  = 64'h0,
  parameter logic [63:0] PULSE_MASK   = 64'h0,
  parameter int          PULSE_CYCLES = 16,
  parameter int          ADDR_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_write,
  input  logic [31:0]           avmm_writedata,
  input  logic                  avmm_read,
  output logic [31:0]           avmm_readdata,
  output logic [GPO_WIDTH-1:0]  gpo,
  output logic                  gpo_changed
);

  localparam int NB = (GPO_WIDTH + 31) / 32;
  localparam int PW = NB * 32;
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

  logic [ADDR_WIDTH-1:0] bank_sel;
  logic [1:0]            reg_sel;
  logic [GPO_WIDTH-1:0]  gpo_q;
  logic [GPO_WIDTH-1:0]  gpo_next;
  logic [GPO_WIDTH-1:0]  lock_q;
  logic [GPO_WIDTH-1:0]  lock_next;
  logic [PW-1:0]         gpo_pad;
  logic [PW-1:0]         lock_pad;
  logic [31:0]           rd_word;

  assign bank_sel = avmm_address >> 2;
  assign reg_sel  = avmm_address[1:0];
  assign gpo      = gpo_q;

  for (genvar i = 0; i < GPO_WIDTH; i++) begin : g_bit
    localparam int B = i / 32;
    localparam int J = i % 32;
    logic hit;
    logic wr_en;
    logic wr_bit;

    assign hit = avmm_write && (bank_sel == ADDR_WIDTH'(B));

    // a locked bit ignores every data write
    always_comb begin
      wr_en  = 1'b0;
      wr_bit = 1'b0;
      if (hit && !lock_q[i]) begin
        unique case (reg_sel)
          2'd0: begin
            wr_en  = 1'b1;
            wr_bit = avmm_writedata[J];
          end
          2'd1: begin
            wr_en  = avmm_writedata[J];
            wr_bit = 1'b1;
          end
          2'd2: begin
            wr_en  = avmm_writedata[J];
            wr_bit = 1'b0;
          end
          default: ;
        endcase
      end
    end

    assign lock_next[i] = lock_q[i] |
      (hit && (reg_sel == 2'd3) && avmm_writedata[J]);

    if (PULSE_MASK[i]) begin : g_pulse
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
          cnt <= '0;
        end else if (wr_en) begin
          cnt <= wr_bit ? CNT_LOAD : '0;
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end

      // a write beats expiry in the same cycle
      assign gpo_next[i] = wr_en ? wr_bit :
        (gpo_q[i] && (cnt == '0)) ? 1'b0 : gpo_q[i];
    end else begin : g_level
      assign gpo_next[i] = wr_en ? wr_bit : gpo_q[i];
    end
  end

  assign gpo_pad  = PW'(gpo_q);
  assign lock_pad = PW'(lock_q);

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NB; b++) begin
      if (bank_sel == ADDR_WIDTH'(b)) begin
        rd_word = (reg_sel == 2'd3) ? lock_pad[b*32 +: 32]
                                    : gpo_pad[b*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gpo_q         <= RESET_VALUE[GPO_WIDTH-1:0];
      lock_q        <= '0;
      avmm_readdata <= '0;
      gpo_changed   <= 1'b0;
    end else begin
      gpo_q       <= gpo_next;
      lock_q      <= lock_next;
      gpo_changed <= |(gpo_next ^ gpo_q);
      if (avmm_read) begin
        avmm_readdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_gen_gpo_ctrl_regs.sv
// Directed bench for gen_gpo_ctrl_regs: 40 GPO bits, pulse on bit 24.
`timescale 1ns/1ps
module tb_gen_gpo_ctrl_regs;

  logic        clk;
  logic        areset;
  logic [3:0]  avmm_address;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic        avmm_read;
  logic [31:0] avmm_readdata;
  logic [39:0] gpo;
  logic        gpo_changed;

  int checks = 0;
  int errors = 0;

  gen_gpo_ctrl_regs #(
    .GPO_WIDTH   (40),
    .RESET_VALUE (64'h3),
    .PULSE_MASK  (64'h0100_0000),
    .PULSE_CYCLES(16),
    .ADDR_WIDTH  (4)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .avmm_address  (avmm_address),
    .avmm_write    (avmm_write),
    .avmm_writedata(avmm_writedata),
    .avmm_read     (avmm_read),
    .avmm_readdata (avmm_readdata),
    .gpo           (gpo),
    .gpo_changed   (gpo_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    avmm_address   = a;
    avmm_writedata = d;
    avmm_write     = 1'b1;
    @(negedge clk);
    avmm_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    avmm_address = a;
    avmm_read    = 1'b1;
    @(negedge clk);
    avmm_read    = 1'b0;
    d = avmm_readdata;
  endtask

  initial begin
    logic [31:0] rdat;
    int n;
    int bad;

    areset = 1'b1;
    avmm_address = '0;
    avmm_write = 1'b0;
    avmm_writedata = '0;
    avmm_read = 1'b0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    #1;
    chk("reset_gpo", 64'(gpo), 64'h3);
    chk("reset_changed", 64'(gpo_changed), 64'h0);
    chk("reset_rdata", 64'(avmm_readdata), 64'h0);
    rd(4'd0, rdat);
    chk("read_value_reset", 64'(rdat), 64'h3);

    wr(4'd0, 32'h0000_00F0);
    chk("value_wr", 64'(gpo), 64'hF0);
    chk("value_changed", 64'(gpo_changed), 64'h1);
    @(negedge clk);
    chk("changed_one_cycle", 64'(gpo_changed), 64'h0);
    wr(4'd1, 32'h1);
    chk("set_wr", 64'(gpo), 64'hF1);
    chk("set_changed", 64'(gpo_changed), 64'h1);
    wr(4'd2, 32'h10);
    chk("clear_wr", 64'(gpo), 64'hE1);
    chk("clear_changed", 64'(gpo_changed), 64'h1);

    wr(4'd3, 32'h1);
    wr(4'd2, 32'h1);
    chk("lock_clear", 64'(gpo), 64'hE1);
    chk("lock_clear_nochg", 64'(gpo_changed), 64'h0);
    wr(4'd0, 32'h0);
    chk("lock_value", 64'(gpo), 64'h01);
    rd(4'd3, rdat);
    chk("lock_read", 64'(rdat), 64'h1);
    wr(4'd3, 32'h0);
    rd(4'd3, rdat);
    chk("lock_sticky", 64'(rdat), 64'h1);

    // read VALUE while SET-ing bit1 in the same cycle
    @(negedge clk);
    avmm_address = 4'd0;
    avmm_read = 1'b1;
    @(negedge clk);
    avmm_read = 1'b0;
    avmm_address = 4'd1;
    avmm_writedata = 32'h2;
    avmm_write = 1'b1;
    avmm_read = 1'b1;
    @(negedge clk);
    avmm_write = 1'b0;
    avmm_read = 1'b0;
    chk("rd_wr_same_cycle", 64'(avmm_readdata), 64'h01);
    chk("rd_wr_gpo", 64'(gpo), 64'h03);

    wr(4'd1, 32'h0100_0000);
    n = 0;
    while (gpo[24] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("pulse_len16", 64'(n), 64'd16);
    chk("pulse_expiry_changed", 64'(gpo_changed), 64'h1);
    chk("pulse_expiry_gpo", 64'(gpo), 64'h03);

    wr(4'd1, 32'h0100_0000);
    n = 1;
    repeat (9) begin
      @(negedge clk);
      if (gpo[24]) n++;
    end
    avmm_address = 4'd1;
    avmm_writedata = 32'h0100_0000;
    avmm_write = 1'b1;
    @(negedge clk);
    avmm_write = 1'b0;
    while (gpo[24] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("pulse_restart_len26", 64'(n), 64'd26);

    wr(4'd4, 32'hFFFF_FFFF);
    chk("bank1_wr", 64'(gpo), 64'hFF_0000_0003);
    rd(4'd4, rdat);
    chk("bank1_rd", 64'(rdat), 64'hFF);
    wr(4'd12, 32'hFFFF_FFFF);
    chk("bank3_wr_ignored", 64'(gpo), 64'hFF_0000_0003);
    chk("bank3_nochg", 64'(gpo_changed), 64'h0);
    rd(4'd12, rdat);
    chk("bank3_rd", 64'(rdat), 64'h0);

    wr(4'd1, 32'h0100_0000);
    repeat (4) @(negedge clk);
    chk("pulse_cycle5_high", 64'(gpo[24]), 64'h1);
    #2 areset = 1'b1;
    #1;
    chk("async_reset_gpo", 64'(gpo), 64'h3);
    chk("async_reset_rdata", 64'(avmm_readdata), 64'h0);
    @(negedge clk);
    areset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gpo_changed || gpo !== 40'h3) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'h0);
    rd(4'd3, rdat);
    chk("lock_cleared", 64'(rdat), 64'h0);
    wr(4'd0, 32'h0);
    chk("unlocked_wr", 64'(gpo), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
